// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and the FU-count default used by the arbiter and the scoreboard.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_FU  = 4;
  localparam int unsigned CDB_TAG_W   = 8;
  localparam int unsigned CDB_VALUE_W = 32;

  // Result broadcast on the common data bus; opaque to the arbiter.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]   tag;
    logic [CDB_VALUE_W-1:0] value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU circular result buffer with registered count and full-based ready.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_en,
  input  cdb_entry_t                     wr_data,
  input  logic                           rd_en,
  output cdb_entry_t                     rd_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count,
  output logic                           ready
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  cdb_entry_t    mem_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_c, pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ready   = (count_q != CW'(BUF_DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_c  = wr_en && ready && !flush;
  assign pop_c   = rd_en && (count_q != '0) && !flush;

  // Pointer and occupancy next-state; flush empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises FU completions onto the CDB with round-robin arbitration.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU    = CDB_NUM_FU,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_complete_valid,
  input  cdb_entry_t [NUM_FU-1:0]   fu_complete_data,
  output logic [NUM_FU-1:0]         fu_complete_ready,
  output logic                      cdb_valid,
  output cdb_entry_t                cdb_data,
  output logic [$clog2(NUM_FU)-1:0] cdb_grant_fu
);

  localparam int unsigned IW = $clog2(NUM_FU);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  cdb_entry_t        rd_data_c [NUM_FU];
  logic [CW-1:0]     count_c   [NUM_FU];
  logic [NUM_FU-1:0] rd_en_c;
  logic              gnt_valid_c;
  logic [IW-1:0]     gnt_idx_c;
  logic [IW-1:0]     cand_c;

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  cdb_entry_t        cdb_data_q, cdb_data_d;
  logic [IW-1:0]     cdb_grant_q, cdb_grant_d;

  for (genvar g = 0; g < int'(NUM_FU); g++) begin : g_fifo
    cdb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (fu_complete_valid[g]),
      .wr_data (fu_complete_data[g]),
      .rd_en   (rd_en_c[g]),
      .rd_data (rd_data_c[g]),
      .count   (count_c[g]),
      .ready   (fu_complete_ready[g])
    );
  end

  // First non-empty buffer at or after rr_ptr, wrapping to 0.
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand_c = IW'((32'(rr_ptr_q) + k) % NUM_FU);
      if (!gnt_valid_c && (count_c[cand_c] != '0)) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  // Dequeue strobe for the granted buffer; suppressed during flush.
  always_comb begin
    rd_en_c = '0;
    if (gnt_valid_c && !flush) rd_en_c[gnt_idx_c] = 1'b1;
  end

  // Broadcast and round-robin next-state; payload and grant hold when idle.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_data_d  = cdb_data_q;
    cdb_grant_d = cdb_grant_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (gnt_valid_c) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = rd_data_c[gnt_idx_c];
      cdb_grant_d = gnt_idx_c;
      rr_ptr_d    = IW'((32'(gnt_idx_c) + 32'd1) % NUM_FU);
    end
  end

  // Output and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_grant_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_grant_q <= cdb_grant_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_grant_fu = cdb_grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, directed corners, random vs queue model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NFU   = 4;
  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [NFU-1:0]       valid;
  cdb_entry_t [NFU-1:0] data;
  logic [NFU-1:0]       ready;
  logic                 cdb_valid;
  cdb_entry_t           cdb_data;
  logic [1:0]           grant;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per FU plus round-robin pointer and output copy.
  cdb_entry_t q [NFU][$];
  int         m_rr;
  bit         m_valid;
  cdb_entry_t m_data;
  int         m_grant;

  typedef struct {
    bit          fl;
    logic [3:0]  vm;
    logic [31:0] base;
    bit          ev;
    bit          cd;
    int          eg;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl [14];

  cdb_arbiter #(.NUM_FU(NFU), .BUF_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .fu_complete_valid (valid),
    .fu_complete_data  (data),
    .fu_complete_ready (ready),
    .cdb_valid         (cdb_valid),
    .cdb_data          (cdb_data),
    .cdb_grant_fu      (grant)
  );

  always #5 clk = ~clk;

  function automatic cdb_entry_t mk(input logic [31:0] v);
    cdb_entry_t e;
    e.tag   = 8'h00;
    e.value = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NFU-1:0] m_ready();
    logic [NFU-1:0] r;
    for (int i = 0; i < NFU; i++) r[i] = (q[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NFU; i++) q[i].delete();
    m_rr = 0; m_valid = 0; m_data = '0; m_grant = 0;
  endtask

  // One clock edge of the model, applied to the inputs that were stable before it.
  task automatic model_edge();
    logic [NFU-1:0] rdy;
    if (flush) begin
      for (int i = 0; i < NFU; i++) q[i].delete();
      m_rr = 0;
      m_valid = 0;
      return;
    end
    rdy = m_ready();
    m_valid = 0;
    for (int k = 0; k < NFU; k++) begin
      int i;
      i = (m_rr + k) % NFU;
      if (!m_valid && q[i].size() > 0) begin
        m_data  = q[i].pop_front();
        m_grant = i;
        m_valid = 1;
        m_rr    = (i + 1) % NFU;
      end
    end
    for (int i = 0; i < NFU; i++)
      if (valid[i] && rdy[i]) q[i].push_back(data[i]);
  endtask

  task automatic check_model();
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_data", 64'(cdb_data), 64'(m_data));
    chk("cdb_grant_fu", 64'(grant), 64'(m_grant));
    chk("fu_ready", 64'(ready), 64'(m_ready()));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_inputs(input bit fl, input logic [3:0] vm, input logic [31:0] base);
    flush = fl;
    valid = vm;
    for (int i = 0; i < NFU; i++) data[i] = mk(base + 32'(i));
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(0, 4'b0000, 32'h0);
    model_reset();
    #12;
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_data", 64'(cdb_data), 64'd0);
    chk("reset_ready", 64'(ready), 64'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-derived vectors: single result, holding, round-robin resume, flush, post-flush grant.
    tbl[0]  = '{0, 4'b0000, 32'h00, 0, 1, 0, 32'h00};
    tbl[1]  = '{0, 4'b0100, 32'hA3, 0, 1, 0, 32'h00};
    tbl[2]  = '{0, 4'b0000, 32'h00, 1, 1, 2, 32'hA5};
    tbl[3]  = '{0, 4'b0000, 32'h00, 0, 1, 2, 32'hA5};
    tbl[4]  = '{0, 4'b1111, 32'h10, 0, 1, 2, 32'hA5};
    tbl[5]  = '{0, 4'b0000, 32'h00, 1, 1, 3, 32'h13};
    tbl[6]  = '{0, 4'b0000, 32'h00, 1, 1, 0, 32'h10};
    tbl[7]  = '{0, 4'b0011, 32'h20, 1, 1, 1, 32'h11};
    tbl[8]  = '{1, 4'b1111, 32'h30, 0, 0, 0, 32'h00};
    tbl[9]  = '{0, 4'b0000, 32'h00, 0, 0, 0, 32'h00};
    tbl[10] = '{0, 4'b1010, 32'h40, 0, 0, 0, 32'h00};
    tbl[11] = '{0, 4'b0000, 32'h00, 1, 1, 1, 32'h41};
    tbl[12] = '{0, 4'b0000, 32'h00, 1, 1, 3, 32'h43};
    tbl[13] = '{0, 4'b0000, 32'h00, 0, 1, 3, 32'h43};
    for (int r = 0; r < 14; r++) begin
      set_inputs(tbl[r].fl, tbl[r].vm, tbl[r].base);
      run_cycle();
      chk($sformatf("tbl%0d_valid", r), 64'(cdb_valid), 64'(tbl[r].ev));
      if (tbl[r].cd) begin
        chk($sformatf("tbl%0d_grant", r), 64'(grant), 64'(tbl[r].eg));
        chk($sformatf("tbl%0d_data", r), 64'(cdb_data), 64'(mk(tbl[r].ed)));
      end
    end

    // Backpressure: saturate all FUs, watch ready fall, then re-present to a freshly drained FU.
    set_inputs(0, 4'b1111, 32'h50); run_cycle();
    chk("bp_ready_a", 64'(ready), 64'hF);
    set_inputs(0, 4'b1111, 32'h60); run_cycle();
    chk("bp_ready_b", 64'(ready), 64'h1);
    chk("bp_data_b", 64'(cdb_data), 64'(mk(32'h50)));
    set_inputs(0, 4'b0001, 32'h70); run_cycle();
    chk("bp_ready_c", 64'(ready), 64'h2);
    chk("bp_grant_c", 64'(grant), 64'd1);
    set_inputs(0, 4'b0010, 32'h80); run_cycle();
    chk("bp_ready_d", 64'(ready), 64'h4);
    chk("bp_data_d", 64'(cdb_data), 64'(mk(32'h52)));
    set_inputs(0, 4'b0000, 32'h0);
    for (int c = 0; c < 10; c++) run_cycle();

    // Random traffic with occasional flush, saturation bursts and one mid-traffic reset.
    for (int c = 0; c < 3000; c++) begin
      logic [NFU-1:0] rdy;
      int rate;
      rdy = m_ready();
      rate = ((c / 200) % 2 == 0) ? 95 : 40;
      flush = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NFU; i++) begin
        valid[i] = rdy[i] && ($urandom_range(0, 99) < rate);
        data[i]  = cdb_entry_t'({8'($urandom), 32'($urandom)});
      end
      if (c == 1500) begin
        rst_n = 1'b0;
        #2;
        chk("midreset_valid", 64'(cdb_valid), 64'd0);
        chk("midreset_data", 64'(cdb_data), 64'd0);
        chk("midreset_grant", 64'(grant), 64'd0);
        chk("midreset_ready", 64'(ready), 64'hF);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_reset_ready", 64'(ready), 64'hF);
        rst_n = 1'b1;
        set_inputs(0, 4'b0000, 32'h0);
        run_cycle();
      end else begin
        run_cycle();
      end
    end

    set_inputs(0, 4'b0000, 32'h0);
    for (int c = 0; c < 12; c++) run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
